// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel feeder.
// Covers the feeder FSM state encoding, the default channel width and the blank pixel value.
package vga_pkg;

    localparam int DEF_DATA_W = 10;

    typedef enum logic [1:0] {
        WAIT_SRC  = 2'd0,
        WAIT_DISP = 2'd1,
        STREAM    = 2'd2,
        RESYNC    = 2'd3
    } feed_state_t;

    localparam logic [DEF_DATA_W-1:0] BLACK = '0;

endpackage

// File: rtl/pixel_fifo_sc.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// The head register is loaded with the entry that will be at the front after this cycle's push/pop.
module pixel_fifo_sc #(
    parameter int WIDTH  = 31,
    parameter int ADDR_W = 10
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [WIDTH-1:0]  head,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_nxt;
    logic              push_ok;
    logic              pop_ok;

    assign full    = count[ADDR_W];
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_nxt  = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_nxt;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // The slot being written this cycle becomes the front only when it is the sole entry
            if (push_ok && (wr_ptr == rd_nxt)) begin
                head <= din;
            end else begin
                head <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers the camera pixel stream and serves one RGB pixel per display request, keeping the
// first camera pixel of a frame aligned with the first request of a display frame.
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iPix_R,
    input  logic [DATA_W-1:0] iPix_G,
    input  logic [DATA_W-1:0] iPix_B,
    input  logic              iPix_SOF,
    input  logic              iPix_Valid,
    output logic              oPix_Ready,
    input  logic              iRequest,
    input  logic              iDisp_SOF,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oAligned,
    output logic              oUnderflow,
    output logic [CNT_W-1:0]  oUflow_Cnt,
    output logic [CNT_W-1:0]  oDrop_Cnt
);

    localparam int ENTRY_W = 3*DATA_W + 1;
    localparam int DEPTH   = 1 << ADDR_W;

    feed_state_t        state;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W:0]    fifo_count;
    logic               wr_en;
    logic               head_sof;
    logic               slip;
    logic               discard;
    logic               serve;
    logic               uflow;
    logic               fifo_pop;

    assign oPix_Ready = (fifo_count != (ADDR_W+1)'(DEPTH));
    assign wr_en      = iPix_Valid && !fifo_full;
    assign head_sof   = fifo_head[ENTRY_W-1];
    assign slip       = !fifo_empty && !head_sof;
    assign fifo_pop   = discard || serve;

    pixel_fifo_sc #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .push   (wr_en),
        .din    ({iPix_SOF, iPix_R, iPix_G, iPix_B}),
        .pop    (fifo_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head),
        .count  (fifo_count)
    );

    // Display frame start is evaluated before the request of the same cycle.
    // An empty FIFO at display frame start is not a slip; requests then count as underflow.
    always_comb begin
        discard = 1'b0;
        serve   = 1'b0;
        uflow   = 1'b0;
        case (state)
            WAIT_SRC, RESYNC: discard = slip;
            WAIT_DISP:        serve   = iRequest && iDisp_SOF;
            STREAM: begin
                if (!(iDisp_SOF && slip)) begin
                    serve = iRequest && !fifo_empty;
                    uflow = iRequest && fifo_empty;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= WAIT_SRC;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oAligned   <= 1'b0;
            oUnderflow <= 1'b0;
            oUflow_Cnt <= '0;
            oDrop_Cnt  <= '0;
        end else begin
            if (iRequest) begin
                if (serve) begin
                    oRed   <= fifo_head[3*DATA_W-1:2*DATA_W];
                    oGreen <= fifo_head[2*DATA_W-1:DATA_W];
                    oBlue  <= fifo_head[DATA_W-1:0];
                end else begin
                    oRed   <= DATA_W'(BLACK);
                    oGreen <= DATA_W'(BLACK);
                    oBlue  <= DATA_W'(BLACK);
                end
            end

            if (uflow) begin
                oUnderflow <= 1'b1;
                if (oUflow_Cnt != '1) begin
                    oUflow_Cnt <= oUflow_Cnt + CNT_W'(1);
                end
            end

            if (discard && (oDrop_Cnt != '1)) begin
                oDrop_Cnt <= oDrop_Cnt + CNT_W'(1);
            end

            case (state)
                WAIT_SRC, RESYNC: begin
                    if (!fifo_empty && head_sof) begin
                        state <= WAIT_DISP;
                    end
                end
                WAIT_DISP: begin
                    if (iDisp_SOF) begin
                        state    <= STREAM;
                        oAligned <= 1'b1;
                    end
                end
                STREAM: begin
                    if (iDisp_SOF && slip) begin
                        state    <= RESYNC;
                        oAligned <= 1'b0;
                    end
                end
                default: begin
                    state    <= WAIT_SRC;
                    oAligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: expected pixels are queued when a request is driven
// and popped when the registered output appears one cycle later.
module tb_vga_pixel_feeder;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 16;

    logic              iCLK;
    logic              iRST_N;
    logic [DATA_W-1:0] iPix_R, iPix_G, iPix_B;
    logic              iPix_SOF, iPix_Valid, iRequest, iDisp_SOF;
    logic              oPix_Ready, oAligned, oUnderflow;
    logic [DATA_W-1:0] oRed, oGreen, oBlue;
    logic [CNT_W-1:0]  oUflow_Cnt, oDrop_Cnt;

    int n_assert;
    int n_fail;
    logic [3*DATA_W-1:0] exp_q[$];

    vga_pixel_feeder dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iPix_R     (iPix_R),
        .iPix_G     (iPix_G),
        .iPix_B     (iPix_B),
        .iPix_SOF   (iPix_SOF),
        .iPix_Valid (iPix_Valid),
        .oPix_Ready (oPix_Ready),
        .iRequest   (iRequest),
        .iDisp_SOF  (iDisp_SOF),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oAligned   (oAligned),
        .oUnderflow (oUnderflow),
        .oUflow_Cnt (oUflow_Cnt),
        .oDrop_Cnt  (oDrop_Cnt)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic write_px(input logic sof, input logic [DATA_W-1:0] v);
        iPix_Valid = 1'b1;
        iPix_SOF   = sof;
        iPix_R     = v;
        iPix_G     = v;
        iPix_B     = v;
        tick();
        iPix_Valid = 1'b0;
        iPix_SOF   = 1'b0;
    endtask

    task automatic step(input logic req, input logic dsof, input logic [DATA_W-1:0] exp_v);
        logic [3*DATA_W-1:0] e;
        iRequest  = req;
        iDisp_SOF = dsof;
        if (req) exp_q.push_back({exp_v, exp_v, exp_v});
        tick();
        iRequest  = 1'b0;
        iDisp_SOF = 1'b0;
        if (req) begin
            e = exp_q.pop_front();
            check("pixel", 32'({oRed, oGreen, oBlue}), 32'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   32'({oRed, oGreen, oBlue}), 32'd0);
        check({tag, "_ready"}, 32'(oPix_Ready), 32'd1);
        check({tag, "_align"}, 32'(oAligned), 32'd0);
        check({tag, "_uflow"}, 32'(oUnderflow), 32'd0);
        check({tag, "_ucnt"},  32'(oUflow_Cnt), 32'd0);
        check({tag, "_dcnt"},  32'(oDrop_Cnt), 32'd0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        iRST_N     = 1'b0;
        iPix_R     = '0;
        iPix_G     = '0;
        iPix_B     = '0;
        iPix_SOF   = 1'b0;
        iPix_Valid = 1'b0;
        iRequest   = 1'b0;
        iDisp_SOF  = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        iRST_N = 1'b1;
        tick();

        // one full line, aligned at the display frame start
        for (int i = 0; i < 640; i++) write_px(i == 0, DATA_W'(i));
        step(1'b0, 1'b0, '0);
        check("t1_wait_disp_align", 32'(oAligned), 32'd0);
        step(1'b0, 1'b1, '0);
        check("t1_align", 32'(oAligned), 32'd1);
        for (int i = 0; i < 640; i++) step(1'b1, 1'b0, DATA_W'(i));
        check("t1_ucnt", 32'(oUflow_Cnt), 32'd0);
        check("t1_uflow", 32'(oUnderflow), 32'd0);

        // junk ahead of a frame is discarded; SOF and request in the same cycle
        iRST_N = 1'b0;
        tick();
        iRST_N = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) write_px(1'b0, DATA_W'(100 + i));
        for (int i = 0; i < 8; i++) write_px(i == 0, DATA_W'(200 + i));
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("t2_drop", 32'(oDrop_Cnt), 32'd3);
        step(1'b1, 1'b1, DATA_W'(200));
        check("t2_align", 32'(oAligned), 32'd1);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, DATA_W'(200 + i));
        check("t2_ucnt", 32'(oUflow_Cnt), 32'd0);

        // underflow: 10 buffered, 12 requests
        for (int i = 0; i < 10; i++) write_px(1'b0, DATA_W'(300 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DATA_W'(300 + i));
        check("t3_no_uflow_yet", 32'(oUnderflow), 32'd0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("t3_uflow", 32'(oUnderflow), 32'd1);
        check("t3_ucnt", 32'(oUflow_Cnt), 32'd2);
        check("t3_align", 32'(oAligned), 32'd1);

        // fill to full, reject one more write, drain intact
        for (int i = 0; i < 1023; i++) write_px(1'b0, DATA_W'(i));
        check("t4_ready_before_last", 32'(oPix_Ready), 32'd1);
        write_px(1'b0, DATA_W'(1023));
        check("t4_ready_full", 32'(oPix_Ready), 32'd0);
        write_px(1'b0, DATA_W'(555));
        check("t4_ready_still_full", 32'(oPix_Ready), 32'd0);
        for (int i = 0; i < 1024; i++) step(1'b1, 1'b0, DATA_W'(i));
        step(1'b1, 1'b0, '0);
        check("t4_ucnt", 32'(oUflow_Cnt), 32'd3);
        check("t4_ready_drained", 32'(oPix_Ready), 32'd1);

        // frame slip: display frame starts while the head is mid-frame
        write_px(1'b1, DATA_W'(400));
        for (int i = 1; i < 6; i++) write_px(1'b0, DATA_W'(400 + i));
        write_px(1'b1, DATA_W'(500));
        write_px(1'b0, DATA_W'(501));
        write_px(1'b0, DATA_W'(502));
        step(1'b1, 1'b0, DATA_W'(400));
        step(1'b1, 1'b0, DATA_W'(401));
        step(1'b0, 1'b1, '0);
        check("t5_resync_align", 32'(oAligned), 32'd0);
        step(1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);
        check("t5_drop", 32'(oDrop_Cnt), 32'd7);
        step(1'b1, 1'b0, '0);
        check("t5_ucnt_unchanged", 32'(oUflow_Cnt), 32'd3);
        check("t5_wait_align", 32'(oAligned), 32'd0);
        step(1'b0, 1'b1, '0);
        check("t5_realign", 32'(oAligned), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'(500 + i));
        check("t5_drop_final", 32'(oDrop_Cnt), 32'd7);

        // reset mid-stream
        for (int i = 0; i < 4; i++) write_px(1'b0, DATA_W'(600 + i));
        step(1'b1, 1'b0, DATA_W'(600));
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        tick();
        iRST_N = 1'b1;
        tick();
        write_px(1'b1, DATA_W'(700));
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("t6_state_wait", 32'(oAligned), 32'd0);
        check("t6_no_old_drops", 32'(oDrop_Cnt), 32'd0);
        step(1'b1, 1'b1, DATA_W'(700));
        check("t6_align", 32'(oAligned), 32'd1);
        check("t6_ucnt", 32'(oUflow_Cnt), 32'd0);
        step(1'b1, 1'b0, '0);
        check("t6_empty_uflow", 32'(oUflow_Cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
